axis_tkeep2seg: RTL and testbench

Parametrised AXI-stream to segmented-bus sideband converter for the 100G datapath. Each accepted AXI-stream beat is split into SEG_WIDTH-bit segments, and the block generates per-segment enable, start-of-packet, end-of-packet, empty-byte count (mty) and error flags. Output is registered behind a skid buffer, so it runs at full throughput. It sits between the RoCE TX stream and the segmented MAC adapter.

---
 rtl/axis_tkeep2seg_if.sv | 35 +++
 rtl/axis_tkeep2seg.sv | 143 ++++++++++++++
 tb/tb_axis_tkeep2seg.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_tkeep2seg_if.sv
// Stream bundle for axis_tkeep2seg: AXI-stream input side plus segmented-bus output side.
// The slave modport is the converter's view; master is the producer/consumer view.
interface axis_tkeep2seg_if #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned SEG_WIDTH  = 128
);
  localparam int unsigned SEGS      = DATA_WIDTH / SEG_WIDTH;
  localparam int unsigned SEG_BYTES = SEG_WIDTH / 8;
  localparam int unsigned MTY_WIDTH = $clog2(SEG_BYTES);

  logic [DATA_WIDTH-1:0]     s_axis_tdata;
  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep;
  logic                      s_axis_tvalid;
  logic                      s_axis_tready;
  logic                      s_axis_tlast;

  logic [DATA_WIDTH-1:0]     m_data;
  logic [SEGS-1:0]           m_ena;
  logic [SEGS-1:0]           m_sop;
  logic [SEGS-1:0]           m_eop;
  logic [SEGS*MTY_WIDTH-1:0] m_mty;
  logic                      m_err;
  logic                      m_valid;
  logic                      m_ready;

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_ready,
    output s_axis_tready, m_data, m_ena, m_sop, m_eop, m_mty, m_err, m_valid
  );

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_ready,
    input  s_axis_tready, m_data, m_ena, m_sop, m_eop, m_mty, m_err, m_valid
  );
endinterface

// File: rtl/axis_tkeep2seg.sv
// AXI-stream to segmented-bus sideband converter: per-segment ena/sop/eop/mty/err,
// registered output with a one-entry skid buffer for full throughput.
module axis_tkeep2seg #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned SEG_WIDTH  = 128,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  axis_tkeep2seg_if.slave      bus,
  output logic [CNT_WIDTH-1:0] err_count
);
  localparam int unsigned SEGS      = DATA_WIDTH / SEG_WIDTH;
  localparam int unsigned SEG_BYTES = SEG_WIDTH / 8;
  localparam int unsigned MTY_WIDTH = $clog2(SEG_BYTES);
  localparam int unsigned KB        = DATA_WIDTH / 8;
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  typedef enum logic [0:0] {StIdle, StInPkt} state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     data;
    logic [SEGS-1:0]           ena;
    logic [SEGS-1:0]           sop;
    logic [SEGS-1:0]           eop;
    logic [SEGS*MTY_WIDTH-1:0] mty;
    logic                      err;
  } beat_t;

  state_e                state_q, state_d;
  beat_t                 out_q, out_d, skid_q, skid_d, beat_in;
  logic                  valid_q, valid_d, skid_full_q, skid_full_d, ready_q;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [KB-1:0]         keep, keep_inc;
  logic                  is_full, is_contig, legal, in_hs, out_hs;
  logic [SEGS-1:0]       seg_any;
  int unsigned           seg_pop [SEGS];

  assign in_hs  = bus.s_axis_tvalid & ready_q;
  assign out_hs = valid_q & bus.m_ready;

  // Sideband decode of the beat currently offered on the input.
  always_comb begin
    keep      = bus.s_axis_tkeep;
    keep_inc  = keep + KB'(1);
    is_full   = &keep;
    // Contiguous-from-LSB and non-zero: adding one clears every set bit.
    is_contig = (keep != '0) && ((keep & keep_inc) == '0);
    legal     = bus.s_axis_tlast ? is_contig : is_full;
    seg_any   = '0;
    for (int unsigned i = 0; i < SEGS; i++) begin
      seg_any[i] = |keep[i*SEG_BYTES +: SEG_BYTES];
      seg_pop[i] = 0;
      for (int unsigned j = 0; j < SEG_BYTES; j++) begin
        seg_pop[i] += 32'(keep[i*SEG_BYTES + j]);
      end
    end

    beat_in      = '0;
    beat_in.data = bus.s_axis_tdata;
    beat_in.ena  = seg_any;
    beat_in.sop  = (state_q == StIdle) ? SEGS'(1) : '0;
    beat_in.err  = ~legal;
    if (bus.s_axis_tlast && legal) begin
      for (int unsigned i = 0; i < SEGS; i++) begin
        // Final segment is the highest one holding any byte.
        if (seg_any[i] && !((i + 1 < SEGS) ? seg_any[(i + 1) % SEGS] : 1'b0)) begin
          beat_in.eop[i] = 1'b1;
          beat_in.mty[i*MTY_WIDTH +: MTY_WIDTH] = MTY_WIDTH'(SEG_BYTES - seg_pop[i]);
        end
      end
    end else if (bus.s_axis_tlast) begin
      beat_in.eop[SEGS-1] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (in_hs) begin
      state_d = bus.s_axis_tlast ? StIdle : StInPkt;
    end
  end

  // Output register plus skid; a held skid beat always drains ahead of new input.
  always_comb begin
    out_d       = out_q;
    valid_d     = valid_q;
    skid_d      = skid_q;
    skid_full_d = skid_full_q;
    if (!valid_q || bus.m_ready) begin
      if (skid_full_q) begin
        out_d       = skid_q;
        valid_d     = 1'b1;
        skid_full_d = 1'b0;
      end else if (in_hs) begin
        out_d   = beat_in;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end else if (in_hs) begin
      skid_d      = beat_in;
      skid_full_d = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (out_hs && out_q.err && cnt_q != CntMax) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      out_q       <= '0;
      skid_q      <= '0;
      valid_q     <= 1'b0;
      skid_full_q <= 1'b0;
      ready_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      valid_q     <= valid_d;
      skid_full_q <= skid_full_d;
      ready_q     <= ~skid_full_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.s_axis_tready = ready_q;
  assign bus.m_data        = out_q.data;
  assign bus.m_ena         = out_q.ena;
  assign bus.m_sop         = out_q.sop;
  assign bus.m_eop         = out_q.eop;
  assign bus.m_mty         = out_q.mty;
  assign bus.m_err         = out_q.err;
  assign bus.m_valid       = valid_q;
  assign err_count         = cnt_q;
endmodule

// File: tb/tb_axis_tkeep2seg.sv
// Scoreboard bench for axis_tkeep2seg: driver pushes expected beats, a negedge monitor
// pops and compares on every output handshake.
module tb_axis_tkeep2seg;
  localparam int unsigned DW = 512;
  localparam int unsigned SW = 128;
  localparam int unsigned CW = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [3:0]    ena;
    logic [3:0]    sop;
    logic [3:0]    eop;
    logic [15:0]   mty;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CW-1:0] err_count;

  always #5 clk = ~clk;

  axis_tkeep2seg_if #(.DATA_WIDTH(DW), .SEG_WIDTH(SW)) bus ();

  axis_tkeep2seg #(.DATA_WIDTH(DW), .SEG_WIDTH(SW), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .err_count (err_count)
  );

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned model_cnt = 0;
  bit          in_pkt = 1'b0;
  bit          tog_en = 1'b0;
  logic [5:0]  pat = 6'b110001;  // m_ready sequence 1,0,0,0,1,1 read from bit 0
  int          pi = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [DW-1:0] d, input logic [3:0] ena, input logic [3:0] sop,
                              input logic [3:0] eop, input logic [15:0] mty, input logic err);
    exp_t e;
    e.data = d; e.ena = ena; e.sop = sop; e.eop = eop; e.mty = mty; e.err = err;
    return e;
  endfunction

  // Reference: find n with keep == 2^n-1, then derive fields arithmetically from n.
  function automatic exp_t model(input logic [DW-1:0] d, input logic [63:0] keep, input logic last,
                                 input logic sop);
    exp_t e;
    int n;
    logic lgl;
    logic [63:0] m;
    e.data = d; e.sop = sop ? 4'b0001 : 4'b0000; e.eop = '0; e.mty = '0;
    n = 0; m = '0; lgl = 1'b0;
    if (!last) lgl = (keep == {64{1'b1}});
    else begin
      for (int k = 1; k <= 64; k++) begin
        m = {m[62:0], 1'b1};
        if (keep == m) begin lgl = 1'b1; n = k; end
      end
    end
    e.err = ~lgl;
    for (int s = 0; s < 4; s++) e.ena[s] = |keep[s*16 +: 16];
    if (lgl && last) begin
      int ee;
      ee = (n - 1) / 16;
      e.ena = 4'((1 << (ee + 1)) - 1);
      e.eop = 4'(1 << ee);
      e.mty[ee*4 +: 4] = 4'(16 * (ee + 1) - n);
    end
    if (!lgl && last) e.eop = 4'b1000;
    return e;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the handshake edge.
  task automatic send(input logic [DW-1:0] d, input logic [63:0] keep, input logic last,
                      input exp_t e);
    int guard;
    bus.s_axis_tdata  = d;
    bus.s_axis_tkeep  = keep;
    bus.s_axis_tlast  = last;
    bus.s_axis_tvalid = 1'b1;
    sb_q.push_back(e);
    guard = 0;
    @(negedge clk);
    while (!bus.s_axis_tready && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout: tready stuck at %0b, required 1", bus.s_axis_tready);
      bus.s_axis_tvalid = 1'b0;
      void'(sb_q.pop_back());
      return;
    end
    @(posedge clk);
    #1;
    bus.s_axis_tvalid = 1'b0;
    in_pkt = ~last;
  endtask

  task automatic send_m(input logic [DW-1:0] d, input logic [63:0] keep, input logic last);
    send(d, keep, last, model(d, keep, last, ~in_pkt));
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 1000) begin
      guard++;
      @(negedge clk);
    end
    check("drain_queue_empty", 64'(sb_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 64'(bus.m_valid), 64'd0);
    check({tag, "_tready"}, 64'(bus.s_axis_tready), 64'd0);
    check({tag, "_side"}, {35'd0, bus.m_ena, bus.m_sop, bus.m_eop, bus.m_mty, bus.m_err}, 64'd0);
    check({tag, "_data_zero"}, 64'(bus.m_data == '0), 64'd1);
    check({tag, "_err_count"}, 64'(err_count), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_pulse");
    sb_q.delete();
    in_pkt    = 1'b0;
    model_cnt = 0;
    @(negedge clk);
    check_reset_outputs("rst_hold");
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("tready_after_release", 64'(bus.s_axis_tready), 64'd1);
  endtask

  always @(posedge clk) begin
    if (tog_en) begin
      #1;
      bus.m_ready = pat[pi];
      pi = (pi + 1) % 6;
    end
  end

  exp_t got, snap, ex;
  bit   stall_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      got = mk(bus.m_data, bus.m_ena, bus.m_sop, bus.m_eop, bus.m_mty, bus.m_err);
      if (stall_prev) check("hold_stable", 64'((got === snap) && bus.m_valid), 64'd1);
      if (bus.m_valid && bus.m_ready) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got output with empty scoreboard, required none");
        end else begin
          ex = sb_q.pop_front();
          checks++;
          if (got !== ex) begin
            errors++;
            $display("FAIL beat: got ena=%h sop=%h eop=%h mty=%h err=%0b data_ok=%0b; expected ena=%h sop=%h eop=%h mty=%h err=%0b",
                     got.ena, got.sop, got.eop, got.mty, got.err, got.data === ex.data,
                     ex.ena, ex.sop, ex.eop, ex.mty, ex.err);
          end
          if (ex.err && model_cnt != (1 << CW) - 1) model_cnt++;
        end
      end
      stall_prev = bus.m_valid && !bus.m_ready;
      snap = got;
    end else begin
      stall_prev = 1'b0;
    end
  end

  logic [DW-1:0] d1;
  time           t0;

  initial begin
    bus.s_axis_tdata  = '0;
    bus.s_axis_tkeep  = '0;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    bus.m_ready       = 1'b1;
    #2;
    check_reset_outputs("init");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("tready_after_release", 64'(bus.s_axis_tready), 64'd1);

    // Single beat, 40 bytes: ena 0111, eop 0100, mty field 2 = 8, latency 1.
    d1 = {16{32'hA5A5_0001}};
    check("valid_before_hs", 64'(bus.m_valid), 64'd0);
    send(d1, 64'h0000_00FF_FFFF_FFFF, 1'b1, mk(d1, 4'b0111, 4'b0001, 4'b0100, 16'h0800, 1'b0));
    check("valid_1cyc_after_hs", 64'(bus.m_valid), 64'd1);
    drain();

    // Three-beat packet, back to back.
    t0 = $time;
    send({16{32'h1111_1111}}, '1, 1'b0,
         mk({16{32'h1111_1111}}, 4'b1111, 4'b0001, 4'b0000, 16'h0000, 1'b0));
    send({16{32'h2222_2222}}, '1, 1'b0,
         mk({16{32'h2222_2222}}, 4'b1111, 4'b0000, 4'b0000, 16'h0000, 1'b0));
    send({16{32'h3333_3333}}, 64'hFFFF, 1'b1,
         mk({16{32'h3333_3333}}, 4'b0001, 4'b0000, 4'b0001, 16'h0000, 1'b0));
    check("three_beats_three_cycles", 64'($time - t0), 64'd30);
    drain();

    // Illegal last beat, then the following beat must be a packet start.
    check("err_count_before", 64'(err_count), 64'd0);
    send({16{32'hDEAD_BEEF}}, 64'hF0F0, 1'b1,
         mk({16{32'hDEAD_BEEF}}, 4'b0001, 4'b0001, 4'b1000, 16'h0000, 1'b1));
    drain();
    check("err_count_after", 64'(err_count), 64'd1);
    send({16{32'h0BAD_F00D}}, 64'hFF, 1'b1,
         mk({16{32'h0BAD_F00D}}, 4'b0001, 4'b0001, 4'b0001, 16'h0008, 1'b0));
    drain();

    // Stall: second beat lands in skid and tready drops.
    bus.m_ready = 1'b0;
    send_m({16{32'h4444_4444}}, '1, 1'b0);
    check("tready_output_only_full", 64'(bus.s_axis_tready), 64'd1);
    send_m({16{32'h5555_5555}}, 64'h0FFF_FFFF_FFFF_FFFF, 1'b1);
    check("tready_skid_full", 64'(bus.s_axis_tready), 64'd0);
    check("valid_while_stalled", 64'(bus.m_valid), 64'd1);
    @(posedge clk);
    #1;
    bus.m_ready = 1'b1;
    drain();

    // 20 random legal packets under a 1,0,0,0,1,1 m_ready pattern.
    pi = 0;
    tog_en = 1'b1;
    for (int p = 0; p < 20; p++) begin
      int len, n;
      logic [63:0] kp;
      len = $urandom_range(1, 4);
      n   = $urandom_range(1, 64);
      kp  = (n == 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
      for (int b = 0; b < len - 1; b++) send_m(rand_data(), '1, 1'b0);
      send_m(rand_data(), kp, 1'b1);
    end
    tog_en = 1'b0;
    @(posedge clk);
    #2;
    bus.m_ready = 1'b1;
    drain();
    check("err_count_random", 64'(err_count), 64'(model_cnt));

    // Reset after the first beat of a 3-beat packet.
    send_m({16{32'h6666_6666}}, '1, 1'b0);
    do_reset();
    send({16{32'h7777_7777}}, '1, 1'b0,
         mk({16{32'h7777_7777}}, 4'b1111, 4'b0001, 4'b0000, 16'h0000, 1'b0));
    send({16{32'h8888_8888}}, '1, 1'b1,
         mk({16{32'h8888_8888}}, 4'b1111, 4'b0000, 4'b1000, 16'h0000, 1'b0));
    drain();

    // Error counter saturation.
    do_reset();
    for (int k = 0; k < (1 << CW) + 3; k++) send_m('0, '0, 1'b0);
    drain();
    check("err_count_saturated", 64'(err_count), 64'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
